// File: rtl/barrel_collision.sv
// rtl/barrel_collision.sv - Mario/barrel hit detection, lives, jump-over scoring and game state.
// All outputs come straight from flops; geometry is evaluated combinationally each cycle.
module barrel_collision #(
    parameter int MARIO_W     = 24,
    parameter int MARIO_H     = 32,
    parameter int ROLL_W      = 32,
    parameter int FALL_W      = 42,
    parameter int BARREL_H    = 24,
    parameter int HIT_CONFIRM = 2,
    parameter int LIVES       = 3,
    parameter int OVER_HOLD   = 64,
    parameter int JUMP_DY     = 40,
    parameter int JUMP_SCORE  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  mario_x,
    input  logic [8:0]  mario_y,
    input  logic [9:0]  barrel_x,
    input  logic [8:0]  barrel_y,
    input  logic [1:0]  barrel_state,
    output logic        over,
    output logic        hit,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic [1:0]  game_state
);

    localparam int CNT_W  = $clog2(HIT_CONFIRM + 1);
    localparam int HOLD_W = $clog2(OVER_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PLAY     = 2'b01,
        HIT      = 2'b10,
        GAMEOVER = 2'b11
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  hit_inc;
    logic [HOLD_W-1:0] hold_cnt;
    logic              jump_armed;

    logic [10:0] mx, my, bx, by, bw, mario_bottom;
    logic        active, horiz, overlap, jump_ok;
    logic [16:0] score_sum;
    logic [15:0] score_next;

    // Widen to 11 bits so right/bottom edges never wrap.
    assign mx = {1'b0, mario_x};
    assign my = {2'b00, mario_y};
    assign bx = {1'b0, barrel_x};
    assign by = {2'b00, barrel_y};
    assign bw = (barrel_state == 2'b10) ? 11'(FALL_W) : 11'(ROLL_W);

    assign active       = (barrel_state == 2'b01) || (barrel_state == 2'b10);
    assign horiz        = active && (mx < bx + bw) && (bx < mx + 11'(MARIO_W));
    assign overlap      = horiz && (my < by + 11'(BARREL_H)) && (by < my + 11'(MARIO_H));
    assign mario_bottom = my + 11'(MARIO_H);
    assign jump_ok      = (by >= mario_bottom) && ((by - mario_bottom) <= 11'(JUMP_DY));

    assign score_sum  = {1'b0, score} + 17'(JUMP_SCORE);
    assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    assign hit_inc    = hit_cnt + CNT_W'(1);
    assign game_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            over       <= 1'b0;
            hit        <= 1'b0;
            lives      <= 2'(LIVES);
            score      <= 16'd0;
            hit_cnt    <= '0;
            hold_cnt   <= '0;
            jump_armed <= 1'b1;
        end else begin
            hit <= 1'b0;
            case (state)
                IDLE: begin
                    over <= 1'b0;
                    if (start) state <= PLAY;
                end
                PLAY: begin
                    if (overlap) begin
                        // Overlap takes precedence over any jump credit this cycle.
                        if (hit_inc == CNT_W'(HIT_CONFIRM)) begin
                            hit     <= 1'b1;
                            over    <= 1'b1;
                            lives   <= lives - 2'd1;
                            hit_cnt <= '0;
                            if (lives == 2'd1) begin
                                state <= GAMEOVER;
                            end else begin
                                state    <= HIT;
                                hold_cnt <= '0;
                            end
                        end else begin
                            hit_cnt <= hit_inc;
                        end
                    end else begin
                        hit_cnt <= '0;
                        if (!horiz) begin
                            jump_armed <= 1'b1;
                        end else if (jump_ok && jump_armed) begin
                            score      <= score_next;
                            jump_armed <= 1'b0;
                        end
                    end
                end
                HIT: begin
                    if (hold_cnt == HOLD_W'(OVER_HOLD - 1)) begin
                        state      <= PLAY;
                        over       <= 1'b0;
                        jump_armed <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                GAMEOVER: begin
                    over <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_collision.sv
// tb/tb_barrel_collision.sv - directed plus randomized checks of barrel_collision against a cycle model.
module tb_barrel_collision;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [9:0]  mario_x, barrel_x;
    logic [8:0]  mario_y, barrel_y;
    logic [1:0]  barrel_state;
    logic        over, hit;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [1:0]  game_state;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: mode 0 idle, 1 play, 2 hit hold, 3 game over.
    int m_mode, m_lives, m_score, m_over, m_hit, m_streak, m_hold_left, m_armed;

    always #5 clk = ~clk;

    barrel_collision dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mario_x      (mario_x),
        .mario_y      (mario_y),
        .barrel_x     (barrel_x),
        .barrel_y     (barrel_y),
        .barrel_state (barrel_state),
        .over         (over),
        .hit          (hit),
        .lives        (lives),
        .score        (score),
        .game_state   (game_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int mx, my, bx, by, bs, bw;
        bit x_ok, ov;
        mx = int'(mario_x);  my = int'(mario_y);
        bx = int'(barrel_x); by = int'(barrel_y);
        bs = int'(barrel_state);
        if (rst) begin
            m_mode = 0; m_lives = 3; m_score = 0; m_over = 0; m_hit = 0;
            m_streak = 0; m_hold_left = 0; m_armed = 1;
            return;
        end
        m_hit = 0;
        bw = (bs == 2) ? 42 : 32;
        x_ok = (bs == 1 || bs == 2) && (mx < bx + bw) && (bx < mx + 24);
        ov = x_ok && (my < by + 24) && (by < my + 32);
        if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (ov) begin
                m_streak++;
                if (m_streak == 2) begin
                    m_hit = 1; m_over = 1; m_streak = 0;
                    m_lives--;
                    m_mode = (m_lives == 0) ? 3 : 2;
                    m_hold_left = 64;
                end
            end else begin
                m_streak = 0;
                if (!x_ok) m_armed = 1;
                else if (by >= my + 32 && by - (my + 32) <= 40 && m_armed == 1) begin
                    m_score = (m_score + 100 > 65535) ? 65535 : m_score + 100;
                    m_armed = 0;
                end
            end
        end else if (m_mode == 2) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_mode = 1; m_over = 0; m_armed = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("over",       32'(over),       32'(m_over));
        check("hit",        32'(hit),        32'(m_hit));
        check("lives",      32'(lives),      32'(m_lives));
        check("score",      32'(score),      32'(m_score));
        check("game_state", 32'(game_state), 32'(m_mode));
        @(negedge clk);
    endtask

    task automatic apply(input int mx, input int my, input int bx, input int by,
                         input int bs, input int st, input int r, input int n);
        mario_x  = 10'(mx); mario_y  = 9'(my);
        barrel_x = 10'(bx); barrel_y = 9'(by);
        barrel_state = 2'(bs);
        start = 1'(st);
        rst   = 1'(r);
        repeat (n) cycle();
    endtask

    initial begin
        apply(100, 200, 300, 210, 1, 0, 1, 1);
        check("rst_lives", 32'(lives), 3);
        check("rst_state", 32'(game_state), 0);
        apply(100, 200, 300, 210, 1, 1, 0, 1);
        check("start_play", 32'(game_state), 1);

        // First hit: two overlap cycles, then 64 cycles of over
        apply(100, 200, 110, 210, 1, 0, 0, 1);
        check("no_hit_yet", 32'(hit), 0);
        apply(100, 200, 110, 210, 1, 0, 0, 1);
        check("hit_pulse", 32'(hit), 1);
        check("hit_lives", 32'(lives), 2);
        check("hit_state", 32'(game_state), 2);
        apply(100, 200, 300, 210, 1, 0, 0, 63);
        check("over_held", 32'(over), 1);
        apply(100, 200, 300, 210, 1, 0, 0, 1);
        check("over_release", 32'(over), 0);
        check("back_play", 32'(game_state), 1);

        // Broken overlap streak never confirms
        apply(100, 200, 110, 210, 1, 0, 0, 1);
        apply(100, 200, 300, 210, 1, 0, 0, 1);
        apply(100, 200, 110, 210, 1, 0, 0, 1);
        check("streak_reset", 32'(lives), 2);

        // Jump-over credit once per pass
        apply(100, 150, 100, 190, 1, 0, 0, 10);
        check("jump_once", 32'(score), 100);
        apply(100, 150, 400, 190, 1, 0, 0, 1);
        apply(100, 150, 100, 190, 1, 0, 0, 3);
        check("jump_rearm", 32'(score), 200);

        // Touching edge: rolling width touches, falling width overlaps
        apply(132, 200, 100, 210, 1, 0, 0, 3);
        check("touch_roll", 32'(lives), 2);
        apply(132, 200, 100, 210, 2, 0, 0, 2);
        check("touch_fall", 32'(lives), 1);
        apply(132, 200, 400, 210, 2, 0, 0, 64);
        apply(132, 200, 100, 210, 2, 0, 0, 2);
        check("gameover", 32'(game_state), 3);
        apply(132, 200, 400, 210, 0, 1, 0, 3);
        apply(132, 200, 400, 210, 0, 0, 0, 3);
        apply(132, 200, 400, 210, 0, 1, 0, 3);
        check("gameover_stuck", 32'(over), 1);
        apply(132, 200, 400, 210, 0, 0, 1, 1);
        check("rst_idle", 32'(game_state), 0);
        check("rst_lives3", 32'(lives), 3);

        // Score saturation
        apply(100, 150, 400, 190, 1, 1, 0, 1);
        for (int i = 0; i < 660; i++) begin
            apply(100, 150, 100, 190, 1, 0, 0, 1);
            apply(100, 150, 400, 190, 1, 0, 0, 1);
        end
        check("score_sat", 32'(score), 32'hFFFF);

        // Randomized segments near Mario so overlaps and jumps occur often
        for (int k = 0; k < 700; k++) begin
            int mx, my, bx, by, r;
            mx = $urandom_range(0, 900);
            my = $urandom_range(0, 400);
            bx = mx + int'($urandom_range(0, 100)) - 50;
            by = my + int'($urandom_range(0, 110)) - 30;
            if (bx < 0) bx = 0;
            if (by < 0) by = 0;
            r = (m_mode == 3 || $urandom_range(0, 60) == 0) ? 1 : 0;
            apply(mx, my, bx, by, int'($urandom_range(0, 2)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0, r, int'($urandom_range(1, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
